// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, data port, shared memory port and error flag of
//   the unified-memory arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives acks,
//            read data, stalls, memory transaction fields and bus_err)
//   master : environment view (pipeline requesters plus the memory model)
// Parameters: AW address width, DW data width.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_stall;
  // data port
  logic          dm_req;
  logic          dm_we;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          dm_stall;
  // memory port
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rdy;
  logic [DW-1:0] mem_rdata;
  // watchdog
  logic          bus_err;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack, if_stall,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_rdata, dm_ack, dm_stall,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdy, mem_rdata,
    output bus_err
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack, if_stall,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack, dm_stall,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdy, mem_rdata,
    input  bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch and the MEM stage.
//   One transaction is outstanding at a time: IDLE grants (data first, it is
//   the older instruction), BUSY_I/BUSY_D hold the latched request until
//   mem_rdy, DONE presents a one-cycle ack, then back to IDLE.
//   A watchdog aborts a BUSY state after TIMEOUT cycles without mem_rdy,
//   returning 32'hDEADBEEF and setting the sticky bus_err.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mem_port_arbiter_if.slave (fetch/data ports, memory port, bus_err)
// Parameters: AW, DW, STARVE_MAX (starvation guard only), TIMEOUT.
// Build option: define ARB_STARVE_GUARD_EN to force a fetch grant after
//   STARVE_MAX consecutive data grants while fetch was waiting.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [DW-1:0] ABORT_DATA = DW'(32'hDEADBEEF);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t        state;
  logic [TW-1:0] wd_cnt;
  logic          fetch_turn;
  logic          grant_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  assign fetch_turn = bus.if_req && (starve_cnt == SW'(STARVE_MAX));
`else
  assign fetch_turn = 1'b0;
`endif

  assign grant_d      = bus.dm_req && !fetch_turn;
  assign bus.if_stall = bus.if_req & ~bus.if_ack;
  assign bus.dm_stall = bus.dm_req & ~bus.dm_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wd_cnt        <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.bus_err   <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt    <= '0;
`endif
    end else begin
      bus.if_ack <= 1'b0;
      bus.dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state         <= BUSY_D;
            wd_cnt        <= '0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_be    <= bus.dm_be;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
`ifdef ARB_STARVE_GUARD_EN
            if (bus.if_req) starve_cnt <= starve_cnt + 1'b1;
`endif
          end else if (bus.if_req) begin
            state         <= BUSY_I;
            wd_cnt        <= '0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'hF;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_cnt    <= '0;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          // Normal completion and watchdog abort share the hand-off to DONE;
          // only the returned data and the error flag differ.
          if (bus.mem_rdy || (wd_cnt == TW'(TIMEOUT - 1))) begin
            if (state == BUSY_I) begin
              bus.if_rdata <= bus.mem_rdy ? bus.mem_rdata : ABORT_DATA;
              bus.if_ack   <= 1'b1;
            end else begin
              bus.dm_rdata <= bus.mem_rdy ? bus.mem_rdata : ABORT_DATA;
              bus.dm_ack   <= 1'b1;
            end
            if (!bus.mem_rdy) bus.bus_err <= 1'b1;
            bus.mem_req <= 1'b0;
            state       <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
